counter_sequencer: RTL and testbench

- Controller that sequences the team's free-running up-counter (clock/reset/enable in, WIDTH-bit count out) through a clear phase, then a run of exactly `run_len` enabled cycles.
- Supports hold (pause) and abort, and counts counter wrap-arounds during the run.
- Reports the final count and wrap total with a one-cycle done pulse.
- Sits between a host requester and one counter instance; owns that counter's reset/enable inputs.

---
 rtl/counter_seq_pkg.sv | 18 +
 rtl/counter_seq_len.sv | 54 +++++
 rtl/counter_sequencer.sv | 147 ++++++++++++++
 tb/tb_counter_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_seq_pkg.sv
// ----------------------------------------------------------------------------
// counter_seq_pkg
//   Shared constants for the counter sequencer:
//     - default widths for the sequenced counter and the run-length/wrap fields
//     - FSM state encoding (plain 2-bit localparams so legacy tools and
//       waveform viewers see the same numeric codes)
// ----------------------------------------------------------------------------
package counter_seq_pkg;

    localparam int DEF_WIDTH = 2;
    localparam int DEF_LEN_W = 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

endpackage

// File: rtl/counter_seq_len.sv
// ----------------------------------------------------------------------------
// counter_seq_len
//   LEN_W-bit loadable down-counter that tracks how many enabled counter
//   cycles are still owed in the current run.
//
//   Ports:
//     clock     in   rising-edge clock
//     reset     in   synchronous, active-high; clears value to 0
//     load      in   load load_val (has priority over dec)
//     load_val  in   value to load
//     dec       in   decrement by one
//     value     out  current count
//     last      out  high when value == 1 (the final owed cycle)
// ----------------------------------------------------------------------------
module counter_seq_len
    import counter_seq_pkg::*;
#(
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [LEN_W-1:0] load_val,
    input  logic             dec,
    output logic [LEN_W-1:0] value,
    output logic             last
);

    logic [LEN_W-1:0] value_q;
    logic [LEN_W-1:0] value_d;

    always_comb begin
        // NOTE: default first, so every path assigns value_d and no latch forms.
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (dec) begin
            value_d = value_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: non-blocking so every flop samples pre-edge values of its peers.
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign last  = (value_q == LEN_W'(1));

endmodule

// File: rtl/counter_sequencer.sv
// ----------------------------------------------------------------------------
// counter_sequencer
//   Drives one free-running up-counter through a run: a single clear cycle,
//   then exactly run_len enabled cycles (stretched by hold), then a one-cycle
//   DONE state that captures the counter value. Counts counter wrap-arounds
//   seen during the run (saturating) and reports completion with a done
//   pulse, or early termination with an aborted pulse.
//
//   Ports:
//     clock       in   rising-edge clock
//     reset       in   synchronous, active-high; clears state and outputs
//     start       in   request a run (only looked at in IDLE)
//     run_len     in   number of enabled counter cycles, sampled with start
//     hold        in   pause the run while high
//     abort       in   end any active run, back to IDLE
//     count_in    in   current output of the sequenced counter
//     cnt_reset   out  counter reset (high during CLEAR)
//     cnt_enable  out  counter enable (RUN and not held)
//     busy        out  high in every state except IDLE
//     done        out  one-cycle pulse after a normal completion
//     aborted     out  one-cycle pulse after an abort
//     result      out  count_in captured on leaving DONE
//     wraps       out  wrap events during the last run, saturating
// ----------------------------------------------------------------------------
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] run_len,
    input  logic             hold,
    input  logic             abort,
    input  logic [WIDTH-1:0] count_in,
    output logic             cnt_reset,
    output logic             cnt_enable,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [WIDTH-1:0] result,
    output logic [LEN_W-1:0] wraps
);

    logic [1:0]       state_q,   state_d;
    logic [LEN_W-1:0] wraps_q,   wraps_d;
    logic [WIDTH-1:0] result_q,  result_d;
    logic             done_q,    done_d;
    logic             aborted_q, aborted_d;

    logic             len_load;
    logic             len_dec;
    logic             len_last;
    logic [LEN_W-1:0] remaining;

    counter_seq_len #(
        .LEN_W (LEN_W)
    ) u_remaining (
        .clock    (clock),
        .reset    (reset),
        .load     (len_load),
        .load_val (run_len),
        .dec      (len_dec),
        .value    (remaining),
        .last     (len_last)
    );

    always_comb begin
        state_d   = state_q;
        wraps_d   = wraps_q;
        result_d  = result_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        len_load  = 1'b0;
        len_dec   = 1'b0;

        // Abort outranks hold and sequencing; partial wraps and the previous
        // result are deliberately left untouched.
        if (abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            aborted_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        len_load = 1'b1;
                        // A zero-length run has nothing to count, so the
                        // counter is left alone and no clear is issued.
                        state_d  = (run_len == '0) ? S_DONE : S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    wraps_d = '0;
                    state_d = S_RUN;
                end
                S_RUN: begin
                    if (!hold) begin
                        len_dec = 1'b1;
                        // count_in at all-ones on an enabled edge means the
                        // counter rolls over on this edge.
                        if ((count_in == '1) && (wraps_q != '1)) begin
                            wraps_d = wraps_q + 1'b1;
                        end
                        if (len_last) begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    result_d = count_in;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            wraps_q   <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wraps_q   <= wraps_d;
            result_q  <= result_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign cnt_reset  = (state_q == S_CLEAR);
    assign cnt_enable = (state_q == S_RUN) && !hold;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign result     = result_q;
    assign wraps      = wraps_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// ----------------------------------------------------------------------------
// tb_counter_sequencer
//   Directed bench for counter_sequencer (WIDTH=2, LEN_W=8) driving a small
//   up-counter from cnt_reset/cnt_enable. Cycle numbering: the cycle that
//   follows the edge sampling start is cycle 1; outputs are sampled 1 time
//   unit after each falling edge.
// ----------------------------------------------------------------------------
module tb_counter_sequencer;

    localparam int WIDTH = 2;
    localparam int LEN_W = 8;
    localparam int MAXC  = 40;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic [LEN_W-1:0] run_len;
    logic             hold;
    logic             abort;
    logic [WIDTH-1:0] count_in;
    logic             cnt_reset;
    logic             cnt_enable;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [WIDTH-1:0] result;
    logic [LEN_W-1:0] wraps;

    int errors = 0;
    int checks = 0;

    // Per-cycle recordings of one scenario (index = cycle number).
    bit               rec_done [1:MAXC];
    bit               rec_abt  [1:MAXC];
    bit               rec_busy [1:MAXC];
    bit               rec_clr  [1:MAXC];
    bit               rec_en   [1:MAXC];
    logic [WIDTH-1:0] rec_res  [1:MAXC];

    always #5 clock = ~clock;

    // The sequenced up-counter: cleared by cnt_reset, +1 per enabled edge.
    logic [WIDTH-1:0] cnt_q = '0;
    always_ff @(posedge clock) begin
        if (cnt_reset)       cnt_q <= '0;
        else if (cnt_enable) cnt_q <= cnt_q + 1'b1;
    end
    assign count_in = cnt_q;

    counter_sequencer #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .run_len    (run_len),
        .hold       (hold),
        .abort      (abort),
        .count_in   (count_in),
        .cnt_reset  (cnt_reset),
        .cnt_enable (cnt_enable),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .result     (result),
        .wraps      (wraps)
    );

    // Raise start for the next rising edge (the start edge).
    task automatic kick(input int len);
        @(negedge clock);
        start   = 1'b1;
        run_len = LEN_W'(len);
    endtask

    // Step n cycles after the start edge, driving hold/abort/start on the
    // listed cycles (0 = never) and recording the outputs of each cycle.
    task automatic run_cycles(input int n, input int hold_from, input int hold_to,
                              input int abort_at, input int s_at, input int s_len,
                              input int s2_at, input int s2_len);
        for (int c = 1; c <= n; c++) begin
            @(negedge clock);
            start = 1'b0;
            if (c == s_at)  begin start = 1'b1; run_len = LEN_W'(s_len);  end
            if (c == s2_at) begin start = 1'b1; run_len = LEN_W'(s2_len); end
            hold  = (c >= hold_from) && (c <= hold_to) && (hold_from != 0);
            abort = (c == abort_at);
            #1;
            rec_done[c] = done;
            rec_abt[c]  = aborted;
            rec_busy[c] = busy;
            rec_clr[c]  = cnt_reset;
            rec_en[c]   = cnt_enable;
            rec_res[c]  = result;
        end
        start = 1'b0;
        hold  = 1'b0;
        abort = 1'b0;
    endtask

    function automatic int first_done(input int n);
        for (int c = 1; c <= n; c++) if (rec_done[c]) return c;
        return -1;
    endfunction

    function automatic int count_clr(input int lo, input int hi);
        int k = 0;
        for (int c = lo; c <= hi; c++) if (rec_clr[c]) k++;
        return k;
    endfunction

    function automatic int count_en(input int lo, input int hi);
        int k = 0;
        for (int c = lo; c <= hi; c++) if (rec_en[c]) k++;
        return k;
    endfunction

    function automatic int count_done(input int lo, input int hi);
        int k = 0;
        for (int c = lo; c <= hi; c++) if (rec_done[c]) k++;
        return k;
    endfunction

    function automatic int count_abt(input int lo, input int hi);
        int k = 0;
        for (int c = lo; c <= hi; c++) if (rec_abt[c]) k++;
        return k;
    endfunction

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; run_len = '0; hold = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        checks++;
        if ({busy, done, aborted, cnt_reset, cnt_enable} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, aborted, cnt_reset, cnt_enable});
        end
        checks++;
        if (result !== 2'd0 || wraps !== 8'd0) begin
            errors++;
            $display("FAIL reset_data: got result=%0d wraps=%0d expected 0 0", result, wraps);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        kick(10);
        run_cycles(15, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (count_clr(1, 15) != 1 || !rec_clr[1]) begin
            errors++;
            $display("FAIL basic_clear: got %0d clear cycles expected 1 in cycle 1", count_clr(1, 15));
        end
        checks++;
        if (count_en(1, 15) != 10) begin
            errors++;
            $display("FAIL basic_enable: got %0d expected 10", count_en(1, 15));
        end
        checks++;
        if (first_done(15) != 13) begin
            errors++;
            $display("FAIL basic_done_cycle: got %0d expected 13", first_done(15));
        end
        checks++;
        if (rec_busy[13] !== 1'b0 || rec_busy[12] !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: got busy12=%0d busy13=%0d expected 1 0", rec_busy[12], rec_busy[13]);
        end
        checks++;
        if (count_done(1, 15) != 1) begin
            errors++;
            $display("FAIL basic_done_pulse: got %0d done cycles expected 1", count_done(1, 15));
        end
        checks++;
        if (result !== 2'd2 || wraps !== 8'd2) begin
            errors++;
            $display("FAIL basic_result: got result=%0d wraps=%0d expected 2 2", result, wraps);
        end
    endtask

    task automatic test_hold();
        kick(10);
        run_cycles(17, 5, 7, 0, 0, 0, 0, 0);
        checks++;
        if (count_en(5, 7) != 0 || count_en(1, 17) != 10) begin
            errors++;
            $display("FAIL hold_enable: got held=%0d total=%0d expected 0 10", count_en(5, 7), count_en(1, 17));
        end
        checks++;
        if (first_done(17) != 16) begin
            errors++;
            $display("FAIL hold_done_cycle: got %0d expected 16", first_done(17));
        end
        checks++;
        if (result !== 2'd2 || wraps !== 8'd2) begin
            errors++;
            $display("FAIL hold_result: got result=%0d wraps=%0d expected 2 2", result, wraps);
        end
    endtask

    task automatic test_zero_len();
        // A 7-cycle run leaves the counter at 3 with one wrap.
        kick(7);
        run_cycles(10, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (first_done(10) != 10 || result !== 2'd3 || wraps !== 8'd1) begin
            errors++;
            $display("FAIL prep7: got done=%0d result=%0d wraps=%0d expected 10 3 1", first_done(10), result, wraps);
        end
        kick(0);
        run_cycles(3, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (count_clr(1, 3) != 0 || count_en(1, 3) != 0) begin
            errors++;
            $display("FAIL zero_ctrl: got clr=%0d en=%0d expected 0 0", count_clr(1, 3), count_en(1, 3));
        end
        checks++;
        if (first_done(3) != 2) begin
            errors++;
            $display("FAIL zero_done_cycle: got %0d expected 2", first_done(3));
        end
        checks++;
        if (result !== 2'd3 || wraps !== 8'd1) begin
            errors++;
            $display("FAIL zero_result: got result=%0d wraps=%0d expected 3 1", result, wraps);
        end
    endtask

    task automatic test_abort();
        // RUN starts in cycle 2, so the 5th RUN cycle is cycle 6.
        kick(10);
        run_cycles(16, 0, 0, 6, 0, 0, 0, 0);
        checks++;
        if (rec_busy[6] !== 1'b1 || rec_busy[7] !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got busy6=%0d busy7=%0d expected 1 0", rec_busy[6], rec_busy[7]);
        end
        checks++;
        if (count_abt(1, 16) != 1 || rec_abt[7] !== 1'b1) begin
            errors++;
            $display("FAIL abort_pulse: got %0d pulses, cycle7=%0d expected 1 1", count_abt(1, 16), rec_abt[7]);
        end
        checks++;
        if (count_done(1, 16) != 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d expected 0", count_done(1, 16));
        end
        checks++;
        if (result !== 2'd3 || wraps !== 8'd1) begin
            errors++;
            $display("FAIL abort_data: got result=%0d wraps=%0d expected 3 1", result, wraps);
        end
    endtask

    task automatic test_back_to_back();
        // Run of 2: done in cycle 5. Start in RUN cycle 2 is ignored; start
        // in the done cycle launches a run of 5 (CLEAR in cycle 6).
        kick(2);
        run_cycles(14, 0, 0, 0, 2, 9, 5, 5);
        checks++;
        if (first_done(14) != 5 || rec_res[5] !== 2'd2) begin
            errors++;
            $display("FAIL b2b_first: got done=%0d result=%0d expected 5 2", first_done(14), rec_res[5]);
        end
        checks++;
        if (count_clr(1, 14) != 2 || rec_clr[6] !== 1'b1 || rec_busy[6] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart: got clr=%0d clr6=%0d busy6=%0d expected 2 1 1", count_clr(1, 14), rec_clr[6], rec_busy[6]);
        end
        checks++;
        if (count_done(1, 14) != 2 || !rec_done[13]) begin
            errors++;
            $display("FAIL b2b_second: got %0d dones, cycle13=%0d expected 2 1", count_done(1, 14), rec_done[13]);
        end
        checks++;
        if (result !== 2'd1 || wraps !== 8'd1) begin
            errors++;
            $display("FAIL b2b_result: got result=%0d wraps=%0d expected 1 1", result, wraps);
        end
    endtask

    task automatic test_reset_mid_run();
        bit stayed_idle;
        kick(200);
        run_cycles(6, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (busy !== 1'b1 || wraps !== 8'd1) begin
            errors++;
            $display("FAIL mid_run_state: got busy=%0d wraps=%0d expected 1 1", busy, wraps);
        end
        @(negedge clock);
        reset = 1'b1; start = 1'b1; run_len = 8'd3;
        @(negedge clock); #1;
        checks++;
        if (busy !== 1'b0 || cnt_enable !== 1'b0 || wraps !== 8'd0 || result !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid_run: got busy=%0d en=%0d wraps=%0d result=%0d expected 0 0 0 0", busy, cnt_enable, wraps, result);
        end
        stayed_idle = 1'b1;
        repeat (3) begin
            @(negedge clock); #1;
            if (busy !== 1'b0 || cnt_reset !== 1'b0) stayed_idle = 1'b0;
        end
        checks++;
        if (!stayed_idle) begin
            errors++;
            $display("FAIL reset_blocks_start: got a run during reset expected none");
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || cnt_reset !== 1'b1) begin
            errors++;
            $display("FAIL start_after_reset: got busy=%0d clr=%0d expected 1 1", busy, cnt_reset);
        end
        run_cycles(8, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (first_done(8) != 5 || result !== 2'd3) begin
            errors++;
            $display("FAIL post_reset_run: got done=%0d result=%0d expected 5 3", first_done(8), result);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_zero_len();
        test_abort();
        test_back_to_back();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
